// File: rtl/eeprom_rw_seq.sv
// eeprom_rw_seq: write-then-verify transaction sequencer in front of an I2C byte driver.
// Writes BYTE_NUM pattern bytes, reads them back and reports pass/fail, error count and first bad address.
module eeprom_rw_seq #(
  parameter int          BYTE_NUM    = 16,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter logic [7:0]  SEED        = 8'hA5,
  parameter int          TWR_CYCLES  = 250_000,
  parameter int          GAP_CYCLES  = 400,
  parameter int          TIMEOUT_CYC = 2_000_000
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst_n,
  input  logic        i_go,
  input  logic        i_flag_done,
  input  logic [7:0]  i_data_read,
  output logic        o_start,
  output logic        o_ctrl_w0_r1,
  output logic [15:0] o_addr,
  output logic [7:0]  o_data_write,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [8:0]  o_err_cnt,
  output logic [15:0] o_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_TWR, S_GAP, S_RD_REQ, S_CHECK, S_FINISH
  } state_t;

  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TWR_LAST = 32'(TWR_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [8:0]  K_LAST   = 9'(BYTE_NUM - 1);

  state_t      r_state, w_state_next;
  logic [31:0] r_cnt, w_cnt_next;
  logic [8:0]  r_k, w_k_next;
  logic        r_rd_phase, w_rd_phase_next;
  logic        r_flag_q;
  logic [7:0]  r_rd_data, w_rd_data_next;
  logic        r_start, w_start_next;
  logic        r_ctrl, w_ctrl_next;
  logic [15:0] r_addr, w_addr_next;
  logic [7:0]  r_wdata, w_wdata_next;
  logic        r_busy, w_busy_next;
  logic        r_done, w_done_next;
  logic        r_pass, w_pass_next;
  logic        r_timeout, w_timeout_next;
  logic [8:0]  r_err_cnt, w_err_cnt_next;
  logic [15:0] r_err_addr, w_err_addr_next;

  logic        w_ev;
  logic [15:0] w_k_addr;
  logic [7:0]  w_k_data;

  // Only the rising edge of the driver's done level counts as a completion.
  assign w_ev     = i_flag_done & ~r_flag_q;
  assign w_k_addr = BASE_ADDR + {7'd0, r_k};
  assign w_k_data = SEED + r_k[7:0];

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_k        <= '0;
      r_rd_phase <= 1'b0;
      r_flag_q   <= 1'b0;
      r_rd_data  <= '0;
      r_start    <= 1'b0;
      r_ctrl     <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err_cnt  <= '0;
      r_err_addr <= 16'hFFFF;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_k        <= w_k_next;
      r_rd_phase <= w_rd_phase_next;
      r_flag_q   <= i_flag_done;
      r_rd_data  <= w_rd_data_next;
      r_start    <= w_start_next;
      r_ctrl     <= w_ctrl_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_pass     <= w_pass_next;
      r_timeout  <= w_timeout_next;
      r_err_cnt  <= w_err_cnt_next;
      r_err_addr <= w_err_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_k_next        = r_k;
    w_rd_phase_next = r_rd_phase;
    w_rd_data_next  = r_rd_data;
    w_start_next    = r_start;
    w_ctrl_next     = r_ctrl;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
    w_pass_next     = r_pass;
    w_timeout_next  = r_timeout;
    w_err_cnt_next  = r_err_cnt;
    w_err_addr_next = r_err_addr;

    case (r_state)
      S_IDLE: begin
        if (i_go) begin
          w_pass_next     = 1'b0;
          w_timeout_next  = 1'b0;
          w_err_cnt_next  = '0;
          w_err_addr_next = 16'hFFFF;
          w_k_next        = '0;
          w_rd_phase_next = 1'b0;
          w_cnt_next      = '0;
          w_busy_next     = 1'b1;
          w_state_next    = S_GAP;
        end
      end

      // Request fields are registered together with the start rise.
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_next   = '0;
          w_start_next = 1'b1;
          w_addr_next  = w_k_addr;
          if (r_rd_phase) begin
            w_ctrl_next  = 1'b1;
            w_state_next = S_RD_REQ;
          end else begin
            w_ctrl_next  = 1'b0;
            w_wdata_next = w_k_data;
            w_state_next = S_WR_REQ;
          end
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end

      S_WR_REQ, S_RD_REQ: begin
        if (w_ev) begin
          w_start_next = 1'b0;
          w_cnt_next   = '0;
          if (r_state == S_RD_REQ) begin
            w_rd_data_next = i_data_read;
            w_state_next   = S_CHECK;
          end else begin
            w_state_next = S_WR_TWR;
          end
        end else if (r_cnt == TMO_LAST) begin
          w_start_next   = 1'b0;
          w_timeout_next = 1'b1;
          w_state_next   = S_FINISH;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end

      S_WR_TWR: begin
        if (r_cnt == TWR_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_GAP;
          if (r_k == K_LAST) begin
            w_k_next        = '0;
            w_rd_phase_next = 1'b1;
          end else begin
            w_k_next = r_k + 9'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end

      S_CHECK: begin
        if (r_rd_data != w_k_data) begin
          if (r_err_cnt != 9'h1FF) w_err_cnt_next = r_err_cnt + 9'd1;
          if (r_err_cnt == 9'd0) w_err_addr_next = w_k_addr;
        end
        w_cnt_next = '0;
        if (r_k == K_LAST) begin
          w_state_next = S_FINISH;
        end else begin
          w_k_next     = r_k + 9'd1;
          w_state_next = S_GAP;
        end
      end

      S_FINISH: begin
        w_pass_next  = (r_err_cnt == 9'd0) && !r_timeout;
        w_done_next  = 1'b1;
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_start      = r_start;
  assign o_ctrl_w0_r1 = r_ctrl;
  assign o_addr       = r_addr;
  assign o_data_write = r_wdata;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_timeout    = r_timeout;
  assign o_err_cnt    = r_err_cnt;
  assign o_err_addr   = r_err_addr;

endmodule

// File: tb/tb_eeprom_rw_seq.sv
// Bench for eeprom_rw_seq: randomized driver/EEPROM model, scoreboard of expected requests and run results.
module tb_eeprom_rw_seq;

  localparam int          NB   = 4;
  localparam logic [15:0] BASE = 16'hFFFE;
  localparam logic [7:0]  SD   = 8'hFE;
  localparam int          TWR  = 100;
  localparam int          GAP  = 10;
  localparam int          TMO  = 1000;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  typedef struct {
    logic        pass;
    logic        timeout;
    logic [8:0]  err_cnt;
    logic [15:0] err_addr;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go;
  logic        flag_done;
  logic [7:0]  data_read;
  logic        o_start, o_ctrl, o_busy, o_done, o_pass, o_timeout;
  logic [15:0] o_addr, o_err_addr;
  logic [7:0]  o_wdata;
  logic [8:0]  o_err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  txn_t exp_txn[$];
  res_t exp_res[$];

  bit          silent    = 1'b0;
  bit          long_hold = 1'b0;
  bit [NB-1:0] corrupt   = '0;
  logic [7:0]  mask [NB];
  logic [7:0]  mem [0:65535];
  int          done_seen = 0;

  always #5 clk = ~clk;

  eeprom_rw_seq #(
    .BYTE_NUM(NB), .BASE_ADDR(BASE), .SEED(SD),
    .TWR_CYCLES(TWR), .GAP_CYCLES(GAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_go(go),
    .i_flag_done(flag_done), .i_data_read(data_read),
    .o_start(o_start), .o_ctrl_w0_r1(o_ctrl), .o_addr(o_addr),
    .o_data_write(o_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_pass(o_pass), .o_timeout(o_timeout), .o_err_cnt(o_err_cnt),
    .o_err_addr(o_err_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: the run is simply "write pattern to BASE+k, then read all back".
  task automatic push_run(input bit tmo);
    txn_t t;
    res_t r;
    int   nerr  = 0;
    int   first = -1;
    for (int k = 0; k < NB; k++) begin
      t.rd   = 1'b0;
      t.addr = 16'((32'(BASE) + k) % 65536);
      t.data = 8'((32'(SD) + k) % 256);
      exp_txn.push_back(t);
      if (tmo) break;
    end
    if (!tmo) begin
      for (int k = 0; k < NB; k++) begin
        t.rd   = 1'b1;
        t.addr = 16'((32'(BASE) + k) % 65536);
        t.data = 8'h00;
        exp_txn.push_back(t);
        if (corrupt[k]) begin
          nerr++;
          if (first < 0) first = k;
        end
      end
    end
    r.timeout  = tmo;
    r.pass     = !tmo && (nerr == 0);
    r.err_cnt  = 9'(nerr);
    r.err_addr = (first < 0) ? 16'hFFFF : 16'((32'(BASE) + first) % 65536);
    exp_res.push_back(r);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start"},    32'(o_start),    32'd0);
    chk({tag, "_ctrl"},     32'(o_ctrl),     32'd0);
    chk({tag, "_addr"},     32'(o_addr),     32'(BASE));
    chk({tag, "_wdata"},    32'(o_wdata),    32'd0);
    chk({tag, "_busy"},     32'(o_busy),     32'd0);
    chk({tag, "_done"},     32'(o_done),     32'd0);
    chk({tag, "_pass"},     32'(o_pass),     32'd0);
    chk({tag, "_timeout"},  32'(o_timeout),  32'd0);
    chk({tag, "_err_cnt"},  32'(o_err_cnt),  32'd0);
    chk({tag, "_err_addr"}, 32'(o_err_addr), 32'hFFFF);
  endtask

  task automatic start_run(input bit tmo);
    chk("idle_before_go", 32'(o_busy), 32'd0);
    push_run(tmo);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("busy_after_go", 32'(o_busy), 32'd1);
  endtask

  task automatic wait_done(input bit extra_go);
    int seen0 = done_seen;
    int cyc   = 0;
    while (done_seen == seen0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (extra_go && cyc == 50 && o_busy) go = 1'b1;
      else go = 1'b0;
    end
    go = 1'b0;
    chk("run_completes", 32'(done_seen != seen0), 32'd1);
  endtask

  // Driver + EEPROM model: answers each request after a random latency with a flag_done level.
  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    logic        wr;
    int          kk;
    flag_done = 1'b0;
    data_read = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && o_start && !silent) begin
        a  = o_addr;
        d  = o_wdata;
        wr = !o_ctrl;
        repeat ($urandom_range(2, 20)) @(negedge clk);
        if (wr) begin
          mem[a] = d;
        end else begin
          kk = int'(16'(a - BASE));
          data_read = mem[a] ^ ((kk < NB && corrupt[kk]) ? mask[kk] : 8'h00);
        end
        flag_done = 1'b1;
        repeat (long_hold ? 200 : $urandom_range(3, 15)) @(negedge clk);
        flag_done = 1'b0;
      end
    end
  end

  // Monitor: request scoreboard, request stability/gap, and run results.
  initial begin
    bit          prev_start = 1'b0;
    bit          done_prev  = 1'b0;
    bit          stable     = 1'b1;
    int          low_cnt    = 1000;
    int          high_cnt   = 0;
    logic [15:0] l_addr;
    logic [7:0]  l_data;
    logic        l_ctrl;
    txn_t        t;
    res_t        r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_start = 1'b0;
        done_prev  = 1'b0;
        low_cnt    = 1000;
      end else begin
        if (o_start && !prev_start) begin
          $display("txn %s addr=%04h data=%02h", o_ctrl ? "RD" : "WR", o_addr, o_wdata);
          chk("gap_low_time", 32'(low_cnt >= GAP), 32'd1);
          if (exp_txn.size() == 0) begin
            chk("unexpected_request", 32'd1, 32'd0);
          end else begin
            t = exp_txn.pop_front();
            chk("req_ctrl", 32'(o_ctrl), 32'(t.rd));
            chk("req_addr", 32'(o_addr), 32'(t.addr));
            if (!t.rd) chk("req_wdata", 32'(o_wdata), 32'(t.data));
          end
          l_addr = o_addr; l_data = o_wdata; l_ctrl = o_ctrl;
          stable = 1'b1; high_cnt = 1;
        end else if (o_start) begin
          high_cnt++;
          if (o_addr != l_addr || o_wdata != l_data || o_ctrl != l_ctrl) stable = 1'b0;
        end else if (prev_start) begin
          chk("req_stable", 32'(stable), 32'd1);
          if (silent) chk("timeout_len", 32'(high_cnt), 32'(TMO));
          low_cnt = 1;
        end else begin
          low_cnt++;
        end
        prev_start = o_start;

        if (o_done) begin
          $display("run done pass=%0d timeout=%0d err_cnt=%0d err_addr=%04h",
                   o_pass, o_timeout, o_err_cnt, o_err_addr);
          chk("done_one_cycle", 32'(done_prev), 32'd0);
          if (exp_res.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            r = exp_res.pop_front();
            chk("res_pass",     32'(o_pass),     32'(r.pass));
            chk("res_timeout",  32'(o_timeout),  32'(r.timeout));
            chk("res_err_cnt",  32'(o_err_cnt),  32'(r.err_cnt));
            chk("res_err_addr", 32'(o_err_addr), 32'(r.err_addr));
            chk("res_busy",     32'(o_busy),     32'd0);
            chk("res_all_reqs", 32'(exp_txn.size()), 32'd0);
          end
          done_seen++;
        end
        done_prev = o_done;
      end
    end
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    go    = 1'b0;
    for (int k = 0; k < NB; k++) mask[k] = 8'h00;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean run, one long-hold run, then random corruption patterns.
    for (int run = 0; run < 6; run++) begin
      corrupt   = (run < 2) ? '0 : NB'($urandom_range(0, (1 << NB) - 1));
      long_hold = (run == 1);
      for (int k = 0; k < NB; k++) mask[k] = 8'($urandom_range(1, 255));
      start_run(1'b0);
      wait_done(run == 3);
    end
    long_hold = 1'b0;

    // Bytes 2 and 3 read back wrong; first bad address wraps to 0000.
    corrupt = 4'b1100;
    for (int k = 0; k < NB; k++) mask[k] = 8'h5A;
    start_run(1'b0);
    wait_done(1'b0);
    corrupt = '0;

    // Driver never completes: the first request must time out.
    silent = 1'b1;
    start_run(1'b1);
    wait_done(1'b0);
    repeat (5) @(negedge clk);
    silent = 1'b0;

    // Reset in the read phase aborts the run at once.
    start_run(1'b0);
    cyc = 0;
    while (!(o_start && o_ctrl) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_read_req", 32'(o_start && o_ctrl), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    exp_txn.delete();
    exp_res.delete();
    repeat (300) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Fresh run after reset, with a stray go while busy.
    start_run(1'b0);
    wait_done(1'b1);
    repeat (20) @(negedge clk);
    chk("idle_at_end", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
